// File: rtl/bus_port_ctrl.sv
// One node of a shared OR-resolved bus: follows transactions announced by the
// control node's header and drives its own beats once it is the named source.
module bus_port_ctrl #(
    parameter int unsigned     DATA_W   = 8,
    parameter int unsigned     ID_W     = 2,
    parameter logic [ID_W-1:0] CTRL_ID  = '1,
    parameter int unsigned     OWN_WAIT = 3,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   my_id,
    input  logic              send_valid,
    input  logic [DATA_W-1:0] send_data,
    input  logic              send_last,
    output logic              send_ready,
    output logic              recv_valid,
    output logic [DATA_W-1:0] recv_data,
    output logic              recv_last,
    output logic              recv_hdr,
    input  logic [DATA_W-1:0] bus_data_in,
    input  logic              bus_valid_in,
    input  logic              bus_last_in,
    output logic [DATA_W-1:0] bus_data_out,
    output logic              bus_valid_out,
    output logic              bus_last_out,
    output logic              bus_drive,
    output logic              timeout_err
);

    if (DATA_W < 3 * ID_W) begin : g_bad_width
        $error("bus_port_ctrl: DATA_W must be at least 3*ID_W");
    end

    localparam int unsigned WCW = (OWN_WAIT > 1) ? $clog2(OWN_WAIT) : 1;
    localparam int unsigned TCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((OWN_WAIT > 0) ? OWN_WAIT - 1 : 0);
    localparam logic [TCW-1:0] TO_LIMIT  = TCW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, TRACK, WAIT, OWN} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   src_q, src_d, dest_q, dest_d;
    logic              ids_vld_q, ids_vld_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic [TCW-1:0]    tcnt_q, tcnt_d, tcnt_inc;
    logic              timeout_err_q, timeout_err_d;
    logic              recv_valid_q, recv_valid_d;
    logic [DATA_W-1:0] recv_data_q, recv_data_d;
    logic              recv_last_q, recv_last_d;
    logic              recv_hdr_q, recv_hdr_d;

    logic is_ctrl, is_src, is_dest, last_beat, to_hit, deliver;

    // src/dest share one valid flag: every ID_W pattern is a legal ID, so
    // "invalid" cannot be encoded in the ID fields themselves.
    assign is_ctrl   = (my_id == CTRL_ID);
    assign is_src    = ids_vld_q && (my_id == src_q);
    assign is_dest   = ids_vld_q && (my_id == dest_q);
    assign last_beat = bus_valid_in && bus_last_in;
    assign tcnt_inc  = tcnt_q + 1'b1;
    assign to_hit    = (TIMEOUT != 0) && !bus_valid_in && (tcnt_inc == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            src_q         <= '0;
            dest_q        <= '0;
            ids_vld_q     <= 1'b0;
            wcnt_q        <= '0;
            tcnt_q        <= '0;
            timeout_err_q <= 1'b0;
            recv_valid_q  <= 1'b0;
            recv_data_q   <= '0;
            recv_last_q   <= 1'b0;
            recv_hdr_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dest_q        <= dest_d;
            ids_vld_q     <= ids_vld_d;
            wcnt_q        <= wcnt_d;
            tcnt_q        <= tcnt_d;
            timeout_err_q <= timeout_err_d;
            recv_valid_q  <= recv_valid_d;
            recv_data_q   <= recv_data_d;
            recv_last_q   <= recv_last_d;
            recv_hdr_q    <= recv_hdr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dest_d        = dest_q;
        ids_vld_d     = ids_vld_q;
        wcnt_d        = wcnt_q;
        tcnt_d        = '0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_valid_in) begin
                    src_d  = bus_data_in[2*ID_W-1:ID_W];
                    dest_d = bus_data_in[3*ID_W-1:2*ID_W];
                    if (!bus_last_in) begin
                        ids_vld_d = 1'b1;
                        state_d   = TRACK;
                    end else begin
                        ids_vld_d = 1'b0;
                    end
                end
            end
            default: begin
                if (!bus_valid_in && TIMEOUT != 0) tcnt_d = tcnt_inc;
                if (state_q == TRACK && is_src && send_valid) begin
                    wcnt_d  = '0;
                    state_d = (OWN_WAIT == 0) ? OWN : WAIT;
                end else if (state_q == WAIT) begin
                    if (wcnt_q == WAIT_LAST) state_d = OWN;
                    else                     wcnt_d  = wcnt_q + 1'b1;
                end
                // A closing beat takes priority over a coincident timeout.
                if (last_beat) begin
                    state_d   = IDLE;
                    ids_vld_d = 1'b0;
                    tcnt_d    = '0;
                end else if (to_hit) begin
                    state_d       = IDLE;
                    ids_vld_d     = 1'b0;
                    tcnt_d        = '0;
                    timeout_err_d = 1'b1;
                end
            end
        endcase

        deliver      = bus_valid_in && !bus_drive &&
                       (state_q == IDLE || is_src || is_dest || is_ctrl);
        recv_valid_d = deliver;
        recv_data_d  = deliver ? bus_data_in : '0;
        recv_last_d  = deliver && bus_last_in;
        recv_hdr_d   = deliver && (state_q == IDLE);
    end

    always_comb begin
        bus_drive     = 1'b0;
        send_ready    = 1'b0;
        bus_valid_out = 1'b0;
        bus_data_out  = '0;
        bus_last_out  = 1'b0;
        case (state_q)
            IDLE:    bus_drive = send_valid && is_ctrl;
            OWN:     bus_drive = 1'b1;
            default: bus_drive = 1'b0;
        endcase
        if (bus_drive) begin
            send_ready    = 1'b1;
            bus_valid_out = send_valid;
            bus_data_out  = send_data;
            bus_last_out  = send_valid && send_last;
        end
    end

    assign recv_valid  = recv_valid_q;
    assign recv_data   = recv_data_q;
    assign recv_last   = recv_last_q;
    assign recv_hdr    = recv_hdr_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_port_ctrl.sv
// Directed bench: four 8-bit nodes (IDs 0..3, control 3) on one OR bus, plus a
// 16-bit/3-bit-ID bank with zero ownership wait (IDs 7,5,2,0).
module tb_bus_port_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic       sv_a [4], sl_a [4], rdy_a [4], vo_a [4], lo_a [4], drv_a [4];
    logic       rv_a [4], rl_a [4], rh_a [4], te_a [4];
    logic [7:0] sd_a [4], do_a [4], rd_a [4];
    logic       ext_v, ext_l;
    logic [7:0] ext_d;
    logic       bv_a, bl_a;
    logic [7:0] bd_a;

    always_comb begin
        bv_a = ext_v;
        bl_a = ext_l;
        bd_a = ext_d;
        for (int i = 0; i < 4; i++) begin
            bv_a = bv_a | vo_a[i];
            bl_a = bl_a | lo_a[i];
            bd_a = bd_a | do_a[i];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_a
        bus_port_ctrl #(.DATA_W(8), .ID_W(2), .CTRL_ID(2'b11), .OWN_WAIT(3), .TIMEOUT(16)) u_node (
            .clk(clk), .rst(rst), .my_id(2'(g)),
            .send_valid(sv_a[g]), .send_data(sd_a[g]), .send_last(sl_a[g]), .send_ready(rdy_a[g]),
            .recv_valid(rv_a[g]), .recv_data(rd_a[g]), .recv_last(rl_a[g]), .recv_hdr(rh_a[g]),
            .bus_data_in(bd_a), .bus_valid_in(bv_a), .bus_last_in(bl_a),
            .bus_data_out(do_a[g]), .bus_valid_out(vo_a[g]), .bus_last_out(lo_a[g]),
            .bus_drive(drv_a[g]), .timeout_err(te_a[g])
        );
    end

    localparam logic [2:0] IDS_B [4] = '{3'd7, 3'd5, 3'd2, 3'd0};

    logic        sv_b [4], sl_b [4], rdy_b [4], vo_b [4], lo_b [4], drv_b [4];
    logic        rv_b [4], rl_b [4], rh_b [4], te_b [4];
    logic [15:0] sd_b [4], do_b [4], rd_b [4];
    logic        bv_b, bl_b;
    logic [15:0] bd_b;

    always_comb begin
        bv_b = 1'b0;
        bl_b = 1'b0;
        bd_b = '0;
        for (int i = 0; i < 4; i++) begin
            bv_b = bv_b | vo_b[i];
            bl_b = bl_b | lo_b[i];
            bd_b = bd_b | do_b[i];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_b
        bus_port_ctrl #(.DATA_W(16), .ID_W(3), .CTRL_ID(3'd7), .OWN_WAIT(0), .TIMEOUT(16)) u_node (
            .clk(clk), .rst(rst), .my_id(IDS_B[g]),
            .send_valid(sv_b[g]), .send_data(sd_b[g]), .send_last(sl_b[g]), .send_ready(rdy_b[g]),
            .recv_valid(rv_b[g]), .recv_data(rd_b[g]), .recv_last(rl_b[g]), .recv_hdr(rh_b[g]),
            .bus_data_in(bd_b), .bus_valid_in(bv_b), .bus_last_in(bl_b),
            .bus_data_out(do_b[g]), .bus_valid_out(vo_b[g]), .bus_last_out(lo_b[g]),
            .bus_drive(drv_b[g]), .timeout_err(te_b[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) begin
            sv_a[i] = 1'b0; sl_a[i] = 1'b0; sd_a[i] = '0;
            sv_b[i] = 1'b0; sl_b[i] = 1'b0; sd_b[i] = '0;
        end
        ext_v = 1'b0; ext_l = 1'b0; ext_d = '0;
    endtask

    task automatic quiesce();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Control node 3 issues header 0x24 (src 1, dest 2) and it is accepted this edge.
    task automatic send_header_a();
        sv_a[3] = 1'b1; sd_a[3] = 8'h24; sl_a[3] = 1'b0;
        tick();
        sv_a[3] = 1'b0; sd_a[3] = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        ext_v = 1'b1; ext_d = 8'h24; ext_l = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (rv_a[i] !== 1'b0) begin n_err++; $display("FAIL reset_recv_valid node%0d got=%b want=0", i, rv_a[i]); end
            n_vec++; if (rd_a[i] !== 8'h00) begin n_err++; $display("FAIL reset_recv_data node%0d got=%h want=00", i, rd_a[i]); end
            n_vec++; if (drv_a[i] !== 1'b0) begin n_err++; $display("FAIL reset_bus_drive node%0d got=%b want=0", i, drv_a[i]); end
            n_vec++; if (te_a[i] !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err node%0d got=%b want=0", i, te_a[i]); end
        end
        rst = 1'b0;
        ext_v = 1'b0; ext_d = '0;
        tick();
        n_vec++; if (rv_a[0] !== 1'b0) begin n_err++; $display("FAIL reset_beat_not_delivered got=%b want=0", rv_a[0]); end
        // Control node still IDLE (header during reset ignored) -> drives as soon as it has a beat.
        sv_a[3] = 1'b1; sd_a[3] = 8'h24;
        #1;
        n_vec++; if (drv_a[3] !== 1'b1) begin n_err++; $display("FAIL reset_ctrl_idle_drive got=%b want=1", drv_a[3]); end
        n_vec++; if (rdy_a[3] !== 1'b1) begin n_err++; $display("FAIL reset_ctrl_idle_ready got=%b want=1", rdy_a[3]); end
        sv_a[3] = 1'b0; sd_a[3] = '0;
        #1;
    endtask

    task automatic test_transaction();
        quiesce();
        sv_a[3] = 1'b1; sd_a[3] = 8'h24;
        #1;
        n_vec++; if (bd_a !== 8'h24) begin n_err++; $display("FAIL txn_header_on_bus got=%h want=24", bd_a); end
        tick();
        sv_a[3] = 1'b0; sd_a[3] = '0;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if ({rv_a[i], rh_a[i], rd_a[i]} !== {2'b11, 8'h24})
                begin n_err++; $display("FAIL txn_hdr_recv node%0d got=%b%b/%h want=11/24", i, rv_a[i], rh_a[i], rd_a[i]); end
        end
        n_vec++; if (rv_a[3] !== 1'b0) begin n_err++; $display("FAIL txn_ctrl_no_self_recv got=%b want=0", rv_a[3]); end
        sv_a[1] = 1'b1; sd_a[1] = 8'hA5; sl_a[1] = 1'b0;
        #1;
        n_vec++; if ({drv_a[1], rdy_a[1]} !== 2'b00) begin n_err++; $display("FAIL txn_track_no_drive got=%b%b want=00", drv_a[1], rdy_a[1]); end
        tick(); // node 1 enters WAIT here
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (drv_a[1] !== 1'b0) begin n_err++; $display("FAIL txn_wait_drive cycle%0d got=%b want=0", k, drv_a[1]); end
            tick();
        end
        n_vec++; if ({drv_a[1], rdy_a[1], vo_a[1]} !== 3'b111) begin n_err++; $display("FAIL txn_own_drive got=%b%b%b want=111", drv_a[1], rdy_a[1], vo_a[1]); end
        tick();
        n_vec++; if ({rv_a[2], rd_a[2], rl_a[2], rh_a[2]} !== {1'b1, 8'hA5, 2'b00})
            begin n_err++; $display("FAIL txn_beat0_dest got=%b/%h/%b/%b want=1/a5/0/0", rv_a[2], rd_a[2], rl_a[2], rh_a[2]); end
        n_vec++; if (rv_a[0] !== 1'b0) begin n_err++; $display("FAIL txn_beat0_node0 got=%b want=0", rv_a[0]); end
        n_vec++; if (rv_a[1] !== 1'b0) begin n_err++; $display("FAIL txn_beat0_self got=%b want=0", rv_a[1]); end
        n_vec++; if ({rv_a[3], rd_a[3]} !== {1'b1, 8'hA5}) begin n_err++; $display("FAIL txn_beat0_ctrl got=%b/%h want=1/a5", rv_a[3], rd_a[3]); end
        sd_a[1] = 8'h5A; sl_a[1] = 1'b1;
        #1;
        n_vec++; if (lo_a[1] !== 1'b1) begin n_err++; $display("FAIL txn_last_out got=%b want=1", lo_a[1]); end
        tick();
        n_vec++; if ({rv_a[2], rd_a[2], rl_a[2]} !== {1'b1, 8'h5A, 1'b1})
            begin n_err++; $display("FAIL txn_beat1_dest got=%b/%h/%b want=1/5a/1", rv_a[2], rd_a[2], rl_a[2]); end
        n_vec++; if ({rv_a[0], rd_a[0]} !== 9'h000) begin n_err++; $display("FAIL txn_beat1_node0 got=%b/%h want=0/00", rv_a[0], rd_a[0]); end
        n_vec++; if (drv_a[1] !== 1'b0) begin n_err++; $display("FAIL txn_back_idle_drive got=%b want=0", drv_a[1]); end
        clear_inputs();
    endtask

    task automatic test_single_beat();
        quiesce();
        ext_v = 1'b1; ext_d = 8'h24; ext_l = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            n_vec++; if ({rv_a[i], rh_a[i], rl_a[i], rd_a[i]} !== {3'b111, 8'h24})
                begin n_err++; $display("FAIL single_hdr node%0d got=%b%b%b/%h want=111/24", i, rv_a[i], rh_a[i], rl_a[i], rd_a[i]); end
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_vec++; if ({rv_a[i], rh_a[i]} !== 2'b00) begin n_err++; $display("FAIL single_hdr_pulse node%0d got=%b%b want=00", i, rv_a[i], rh_a[i]); end
        end
        sv_a[3] = 1'b1;
        #1;
        n_vec++; if (drv_a[3] !== 1'b1) begin n_err++; $display("FAIL single_ctrl_still_idle got=%b want=1", drv_a[3]); end
        clear_inputs();
        #1;
    endtask

    task automatic test_timeout();
        quiesce();
        send_header_a();
        for (int k = 1; k <= 16; k++) begin
            if (k < 16) begin
                n_vec++; if (te_a[0] !== 1'b0) begin n_err++; $display("FAIL timeout_early cycle%0d got=%b want=0", k - 1, te_a[0]); end
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (te_a[i] !== 1'b1) begin n_err++; $display("FAIL timeout_pulse node%0d got=%b want=1", i, te_a[i]); end
        end
        sv_a[3] = 1'b1;
        #1;
        n_vec++; if (drv_a[3] !== 1'b1) begin n_err++; $display("FAIL timeout_ctrl_idle got=%b want=1", drv_a[3]); end
        sv_a[3] = 1'b0;
        tick();
        n_vec++; if (te_a[0] !== 1'b0) begin n_err++; $display("FAIL timeout_one_cycle got=%b want=0", te_a[0]); end
    endtask

    task automatic test_reset_in_own();
        quiesce();
        send_header_a();
        sv_a[1] = 1'b1; sd_a[1] = 8'hA5;
        for (int k = 0; k < 4; k++) tick();
        n_vec++; if (drv_a[1] !== 1'b1) begin n_err++; $display("FAIL rstown_reached_own got=%b want=1", drv_a[1]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (drv_a[1] !== 1'b0) begin n_err++; $display("FAIL rstown_drive_drop got=%b want=0", drv_a[1]); end
        n_vec++; if ({rv_a[2], rv_a[3]} !== 2'b00) begin n_err++; $display("FAIL rstown_recv_clear got=%b%b want=00", rv_a[2], rv_a[3]); end
        sv_a[1] = 1'b0; sd_a[1] = '0;
        send_header_a();
        n_vec++; if ({rv_a[0], rh_a[0], rd_a[0]} !== {2'b11, 8'h24})
            begin n_err++; $display("FAIL rstown_next_header got=%b%b/%h want=11/24", rv_a[0], rh_a[0], rd_a[0]); end
    endtask

    task automatic test_last_at_timeout();
        quiesce();
        send_header_a();
        for (int k = 0; k < 15; k++) tick();
        ext_v = 1'b1; ext_l = 1'b1; ext_d = 8'h77;
        tick();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (te_a[i] !== 1'b0) begin n_err++; $display("FAIL lastto_no_err node%0d got=%b want=0", i, te_a[i]); end
        end
        n_vec++; if ({rv_a[2], rl_a[2], rd_a[2]} !== {2'b11, 8'h77})
            begin n_err++; $display("FAIL lastto_dest_recv got=%b%b/%h want=11/77", rv_a[2], rl_a[2], rd_a[2]); end
        n_vec++; if (rv_a[0] !== 1'b0) begin n_err++; $display("FAIL lastto_node0 got=%b want=0", rv_a[0]); end
        tick();
        n_vec++; if (te_a[0] !== 1'b0) begin n_err++; $display("FAIL lastto_no_err_late got=%b want=0", te_a[0]); end
        sv_a[3] = 1'b1;
        #1;
        n_vec++; if (drv_a[3] !== 1'b1) begin n_err++; $display("FAIL lastto_ctrl_idle got=%b want=1", drv_a[3]); end
        clear_inputs();
        #1;
    endtask

    task automatic test_wide_params();
        quiesce();
        // src 5 in [5:3], dest 2 in [8:6]
        sv_b[0] = 1'b1; sd_b[0] = 16'h00A8;
        tick();
        sv_b[0] = 1'b0; sd_b[0] = '0;
        n_vec++; if ({rv_b[3], rh_b[3], rd_b[3]} !== {2'b11, 16'h00A8})
            begin n_err++; $display("FAIL wide_hdr_node0 got=%b%b/%h want=11/00a8", rv_b[3], rh_b[3], rd_b[3]); end
        sv_b[1] = 1'b1; sd_b[1] = 16'h1234; sl_b[1] = 1'b1;
        #1;
        n_vec++; if (drv_b[1] !== 1'b0) begin n_err++; $display("FAIL wide_track_no_drive got=%b want=0", drv_b[1]); end
        tick();
        n_vec++; if ({drv_b[1], rdy_b[1]} !== 2'b11) begin n_err++; $display("FAIL wide_own_next_cycle got=%b%b want=11", drv_b[1], rdy_b[1]); end
        tick();
        n_vec++; if ({rv_b[2], rl_b[2], rh_b[2], rd_b[2]} !== {3'b110, 16'h1234})
            begin n_err++; $display("FAIL wide_dest_recv got=%b%b%b/%h want=110/1234", rv_b[2], rl_b[2], rh_b[2], rd_b[2]); end
        n_vec++; if (rv_b[3] !== 1'b0) begin n_err++; $display("FAIL wide_node0_skip got=%b want=0", rv_b[3]); end
        n_vec++; if (rv_b[1] !== 1'b0) begin n_err++; $display("FAIL wide_self_skip got=%b want=0", rv_b[1]); end
        n_vec++; if (drv_b[1] !== 1'b0) begin n_err++; $display("FAIL wide_back_idle got=%b want=0", drv_b[1]); end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_transaction();
        test_single_beat();
        test_timeout();
        test_reset_in_own();
        test_last_at_timeout();
        test_wide_params();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
